multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//   Multi-cycle sequencer for the RV32 datapath: steps each instruction through
//   FETCH/DECODE/EXECUTE/MEM/WB. Per state, it drives datapath selects and write
//   enables over one shared memory port with a req/ready handshake. Also holds a
//   memory-wait watchdog, an illegal-opcode trap and a retired-instruction counter.
// PARAMETERS
//   MEM_TIMEOUT  16  max cycles a memory wait state may last before TRAP; 0 = watchdog off
//   WDOG_W       8   watchdog counter width; must hold MEM_TIMEOUT
//   COUNT_W      32  width of retired-instruction counter
// PORTS
//   clk          in   1        rising-edge clock
//   rst_n        in   1        asynchronous, active-low reset
//   run          in   1        level enable, sampled in IDLE and at instruction retire
//   opcode       in   7        IR[6:0], stable from DECODE until retire
//   zero         in   1        ALU zero flag
//   mem_ready    in   1        memory completes current req this cycle
//   mem_req      out  1        memory access request
//   mem_we       out  1        1 = write (store), valid with mem_req
//   iord         out  1        mem address select: 0 = PC, 1 = ALUOut
//   ir_write     out  1        load IR from mem rdata
//   pc_write     out  1        load PC
//   pc_src       out  1        PC source: 0 = ALU result (PC+4), 1 = ALUOut (branch target)
//   alu_src_a    out  1        0 = PC, 1 = rs1
//   alu_src_b    out  2        00 = rs2, 01 = const 4, 10 = imm, 11 = branch imm
//   alu_op       out  2        00 = add, 01 = sub/compare, 10 = funct-decoded
//   reg_write    out  1        register file write enable
//   mem_to_reg   out  1        WB source: 0 = ALUOut, 1 = mem data
//   state        out  4        current state code (debug)
//   illegal      out  1        sticky: trapped on undecodable opcode
//   timeout      out  1        sticky: trapped on watchdog expiry
//   retired      out  COUNT_W  instructions retired, wraps modulo 2^COUNT_W
// BEHAVIOUR
//   State, watchdog, flags and counter are registers; outputs decode combinationally
//   from state plus mem_ready/zero. Unlisted outputs are 0 in every state.
//   Reset (async, any state, mid-access included): state=IDLE(0), all outputs 0,
//   retired=0, illegal=timeout=0, watchdog=0.
//   IDLE(0):     run=1 -> FETCH, else stay.
//   FETCH(1):    mem_req=1, iord=0, alu_src_b=01, alu_op=00; on mem_ready:
//                ir_write=1, pc_write=1, pc_src=0 -> DECODE.
//   DECODE(2):   alu_src_b=11, alu_op=00 (branch target into ALUOut). Dispatch:
//                0000011/0100011 -> MEM_ADDR; 0110011 -> EXECUTE; 1100011 -> BRANCH;
//                any other -> TRAP, illegal<=1.
//   MEM_ADDR(3): alu_src_a=1, alu_src_b=10, alu_op=00; load -> MEM_READ, store -> MEM_WRITE.
//   MEM_READ(4): mem_req=1, iord=1; mem_ready -> MEM_WB.
//   MEM_WB(5):   reg_write=1, mem_to_reg=1; retire.
//   MEM_WRITE(6): mem_req=1, mem_we=1, iord=1; mem_ready -> retire.
//   EXECUTE(7):  alu_src_a=1, alu_src_b=00, alu_op=10 -> ALU_WB.
//   ALU_WB(8):   reg_write=1, mem_to_reg=0; retire.
//   BRANCH(9):   alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1, pc_write=zero; retire.
//   TRAP(15):    all outputs 0; run ignored; exit only by reset.
//   Retire: retired+1 (wraps); next = FETCH if run=1, else IDLE.
//   Watchdog (wait states 1,4,6): cleared on entering the state; +1 each cycle mem_req=1
//   and mem_ready=0. Count reaching MEM_TIMEOUT with mem_ready=0 -> TRAP, timeout<=1,
//   mem_req drops next cycle. mem_ready in that same cycle wins: normal completion.
//   mem_ready outside wait states is ignored.
//   Minimum latency at zero wait: R-type 4, BEQ 3, LW 5, SW 4 cycles.
// TESTING
//   1 run=1, R-type 0110011, mem_ready=1 -> states 1,2,7,8,1; reg_write=1 only in 8; retired=1.
//   2 LW 0000011, mem_ready low 3 cycles in MEM_READ -> 4 cycles in state 4, then 5
//     with reg_write=mem_to_reg=1; retired increments once.
//   3 BEQ, zero=1 -> pc_write=pc_src=1 in state 9; repeat with zero=0 -> pc_write=0; both retire.
//   4 opcode 1111111 -> DECODE then TRAP(15), illegal=1, all outputs 0, run ignored until rst_n=0.
//   5 MEM_TIMEOUT=4, mem_ready=0 in FETCH -> TRAP after 4 cycles, timeout=1;
//     mem_ready=1 on the 4th cycle -> DECODE instead.
//   6 rst_n low mid-MEM_WRITE -> async: state=0, mem_req=mem_we=0, retired=0;
//     COUNT_W=4, 16 retires -> retired wraps to 0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Shared memory port between the multicycle sequencer and the memory.
//   mem_req   : access request, held for the whole wait state
//   mem_we    : 1 = write (store), meaningful only with mem_req
//   iord      : address select, 0 = PC, 1 = ALUOut
//   mem_ready : memory completes the current request this cycle
// master = controller side, slave = memory side.
interface multicycle_controller_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output iord,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  iord,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for the RV32 datapath. Each instruction is stepped
// through FETCH/DECODE/EXECUTE/MEM/WB; every state drives datapath selects and
// write enables and uses one shared memory port (req/ready).
// Also contains a memory-wait watchdog, an illegal-opcode trap and a counter of
// retired instructions.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   run            level enable, sampled in IDLE and at instruction retire
//   opcode         IR[6:0], stable from DECODE until retire
//   zero           ALU zero flag (qualifies the branch PC write)
//   mem            memory handshake (master modport)
//   ir_write .. mem_to_reg   datapath controls, decoded from the current state
//   state          current state code (debug)
//   illegal        sticky, trapped on an undecodable opcode
//   timeout        sticky, trapped on watchdog expiry
//   retired        retired-instruction count, wraps
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned WDOG_W      = 8,
  parameter int unsigned COUNT_W     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic [6:0]             opcode,
  input  logic                   zero,
  multicycle_controller_if.master mem,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic                   pc_src,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             alu_op,
  output logic                   reg_write,
  output logic                   mem_to_reg,
  output logic [3:0]             state,
  output logic                   illegal,
  output logic                   timeout,
  output logic [COUNT_W-1:0]     retired
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_TRAP      = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // One extra bit so the incremented count can be compared without wrapping.
  localparam logic [WDOG_W:0] WDOG_LIMIT = (WDOG_W+1)'(MEM_TIMEOUT);
  localparam bit              WDOG_EN    = (MEM_TIMEOUT != 32'd0);

  state_t              state_r;
  logic [WDOG_W-1:0]   wdog_r;
  logic                illegal_r;
  logic                timeout_r;
  logic [COUNT_W-1:0]  retired_r;

  logic                wait_state_s;
  logic [WDOG_W:0]     wdog_inc_s;
  logic                expire_s;
  state_t              retire_next_s;
  logic                mem_req_s;
  logic                mem_we_s;
  logic                iord_s;

  assign wait_state_s  = (state_r == S_FETCH) || (state_r == S_MEM_READ) ||
                         (state_r == S_MEM_WRITE);
  assign wdog_inc_s    = {1'b0, wdog_r} + (WDOG_W+1)'(1'b1);
  // A ready in the expiry cycle still completes the access normally.
  assign expire_s      = WDOG_EN && wait_state_s && !mem.mem_ready &&
                         (wdog_inc_s >= WDOG_LIMIT);
  assign retire_next_s = run ? S_FETCH : S_IDLE;

  // Sequencer: state, watchdog, sticky trap flags and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      wdog_r    <= '0;
      illegal_r <= 1'b0;
      timeout_r <= 1'b0;
      retired_r <= '0;
    end else begin
      // Watchdog only survives a cycle spent waiting in the same state, so it
      // is implicitly cleared on entry to every wait state.
      wdog_r <= '0;
      case (state_r)
        S_IDLE: begin
          if (run) state_r <= S_FETCH;
        end
        S_FETCH: begin
          if (mem.mem_ready) begin
            state_r <= S_DECODE;
          end else if (expire_s) begin
            state_r   <= S_TRAP;
            timeout_r <= 1'b1;
          end else begin
            wdog_r <= wdog_inc_s[WDOG_W-1:0];
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: state_r <= S_MEM_ADDR;
            OP_RTYPE:          state_r <= S_EXECUTE;
            OP_BRANCH:         state_r <= S_BRANCH;
            default: begin
              state_r   <= S_TRAP;
              illegal_r <= 1'b1;
            end
          endcase
        end
        S_MEM_ADDR: begin
          if (opcode == OP_LOAD) state_r <= S_MEM_READ;
          else                   state_r <= S_MEM_WRITE;
        end
        S_MEM_READ: begin
          if (mem.mem_ready) begin
            state_r <= S_MEM_WB;
          end else if (expire_s) begin
            state_r   <= S_TRAP;
            timeout_r <= 1'b1;
          end else begin
            wdog_r <= wdog_inc_s[WDOG_W-1:0];
          end
        end
        S_MEM_WRITE: begin
          if (mem.mem_ready) begin
            state_r   <= retire_next_s;
            retired_r <= retired_r + COUNT_W'(1'b1);
          end else if (expire_s) begin
            state_r   <= S_TRAP;
            timeout_r <= 1'b1;
          end else begin
            wdog_r <= wdog_inc_s[WDOG_W-1:0];
          end
        end
        S_EXECUTE: state_r <= S_ALU_WB;
        S_MEM_WB, S_ALU_WB, S_BRANCH: begin
          state_r   <= retire_next_s;
          retired_r <= retired_r + COUNT_W'(1'b1);
        end
        S_TRAP: state_r <= S_TRAP;
        // Unused encodings fall back to a quiet, restartable state.
        default: state_r <= S_IDLE;
      endcase
    end
  end

  // Datapath control decode from the current state plus mem_ready/zero.
  always_comb begin
    mem_req_s  = 1'b0;
    mem_we_s   = 1'b0;
    iord_s     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    case (state_r)
      S_FETCH: begin
        // ALU computes PC+4 while the instruction word is being read.
        mem_req_s = 1'b1;
        alu_src_b = 2'b01;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end else begin
          ir_write = 1'b0;
          pc_write = 1'b0;
        end
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_req_s = 1'b1;
        iord_s    = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_req_s = 1'b1;
        mem_we_s  = 1'b1;
        iord_s    = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALU_WB: reg_write = 1'b1;
      S_BRANCH: begin
        // Compare rs1-rs2; the target computed in DECODE sits in ALUOut.
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 1'b1;
        pc_write  = zero;
      end
      default: begin
        mem_req_s = 1'b0;
      end
    endcase
  end

  assign mem.mem_req = mem_req_s;
  assign mem.mem_we  = mem_we_s;
  assign mem.iord    = iord_s;
  assign state       = state_r;
  assign illegal     = illegal_r;
  assign timeout     = timeout_r;
  assign retired     = retired_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Stimulus generates whole
// instructions (class, wait counts, zero, run at retire); each cycle's expected
// observable vector is pushed into a queue and a negedge monitor compares it.
module tb_multicycle_controller;
  localparam int TO = 4;
  localparam int CW = 4;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          zero = 1'b0;
  logic [6:0]    opcode = 7'd0;
  logic          ir_write, pc_write, pc_src, alu_src_a, reg_write, mem_to_reg;
  logic [1:0]    alu_src_b, alu_op;
  logic [3:0]    state;
  logic          illegal, timeout;
  logic [CW-1:0] retired;

  multicycle_controller_if mif();

  multicycle_controller #(.MEM_TIMEOUT(TO), .WDOG_W(8), .COUNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .opcode     (opcode),
    .zero       (zero),
    .mem        (mif),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .state      (state),
    .illegal    (illegal),
    .timeout    (timeout),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  // {state, mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
  //  alu_src_b, alu_op, reg_write, mem_to_reg, illegal, timeout, retired}
  logic [22:0] act;
  assign act = {state, mif.mem_req, mif.mem_we, mif.iord, ir_write, pc_write,
                pc_src, alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg,
                illegal, timeout, retired};

  logic [22:0]   expq[$];
  int            total = 0;
  int            bad = 0;
  logic [CW-1:0] m_ret = '0;
  bit            m_ill = 1'b0;
  bit            m_to = 1'b0;

  task automatic check(input string name, input logic [22:0] got, input logic [22:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s @%0t: got %h expected %h (state got %0d expected %0d)",
               name, $time, got, want, got[22:19], want[22:19]);
    end
  endtask

  // Expected controls per state code, straight from the state/output table.
  function automatic logic [12:0] ctl_of(input int st, input bit rdy, input bit z);
    //          req   we    iord  irw   pcw   pcsrc srca  srcb   aluop  regw  m2r
    case (st)
      1: return {1'b1, 1'b0, 1'b0, rdy,  rdy,  1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0};
      2: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0};
      3: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0};
      4: return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
      5: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1};
      6: return {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
      7: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0};
      8: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
      9: return {1'b0, 1'b0, 1'b0, 1'b0, z,    1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0};
      default: return 13'd0;
    endcase
  endfunction

  function automatic bit rnd();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] ill_op();
    logic [6:0] o;
    for (int k = 0; k < 32; k++) begin
      o = 7'($urandom);
      if (o != OP_R && o != OP_LW && o != OP_SW && o != OP_BEQ) return o;
    end
    return 7'b1111111;
  endfunction

  // One clock cycle: drive inputs, queue the expected view of this cycle.
  task automatic cyc(input int st, input bit rdy, input bit rn);
    mif.mem_ready = rdy;
    run = rn;
    expq.push_back({4'(st), ctl_of(st, rdy, zero), m_ill, m_to, m_ret});
    @(posedge clk);
    #1;
  endtask

  // Whole instruction starting in FETCH. cls: 0 R, 1 LW, 2 SW, 3 BEQ,
  // 4 opcode 1111111, 5 random illegal. fw/mw = wait cycles before ready.
  task automatic instr(input int cls, input int fw, input int mw, input bit z, input bit ra);
    case (cls)
      0: opcode = OP_R;
      1: opcode = OP_LW;
      2: opcode = OP_SW;
      3: opcode = OP_BEQ;
      4: opcode = 7'b1111111;
      default: opcode = ill_op();
    endcase
    zero = z;
    for (int i = 0; i <= fw; i++) cyc(1, (i == fw), 1'b1);
    cyc(2, rnd(), 1'b1);
    case (cls)
      0: begin cyc(7, rnd(), 1'b1); cyc(8, rnd(), ra); end
      1: begin
        cyc(3, rnd(), 1'b1);
        for (int i = 0; i <= mw; i++) cyc(4, (i == mw), 1'b1);
        cyc(5, rnd(), ra);
      end
      2: begin
        cyc(3, rnd(), 1'b1);
        for (int i = 0; i <= mw; i++) cyc(6, (i == mw), (i == mw) ? ra : 1'b1);
      end
      3: cyc(9, rnd(), ra);
      default: begin
        m_ill = 1'b1;
        repeat (3) cyc(15, rnd(), rnd());
      end
    endcase
    if (cls < 4) begin
      m_ret = m_ret + 1'b1;
      if (!ra) begin
        cyc(0, rnd(), 1'b0);
        cyc(0, rnd(), 1'b1);
      end
    end
  endtask

  // Asynchronous reset in the middle of a cycle; checked before any clock edge.
  task automatic do_reset(input string name);
    #2;
    rst_n = 1'b0;
    #1;
    check(name, act, 23'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_ret = '0;
    m_ill = 1'b0;
    m_to  = 1'b0;
  endtask

  // Scoreboard monitor: compares every queued expectation mid-cycle.
  always @(negedge clk) begin
    logic [22:0] e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("cycle", act, e);
    end
  end

  initial begin
    mif.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", act, 23'd0);
    rst_n = 1'b1;

    // IDLE holds without run, mem_ready ignored there
    cyc(0, 1'b1, 1'b0);
    cyc(0, 1'b0, 1'b1);

    instr(0, 0, 0, 1'b0, 1'b1);          // R-type, zero wait
    instr(1, 0, 3, 1'b0, 1'b1);          // LW, 3 wait cycles in MEM_READ
    instr(3, 0, 0, 1'b1, 1'b1);          // BEQ taken
    instr(3, 0, 0, 1'b0, 1'b1);          // BEQ not taken
    instr(2, 1, 2, 1'b0, 1'b0);          // SW, then drop to IDLE
    instr(0, TO - 1, 0, 1'b0, 1'b1);     // ready on the last allowed FETCH cycle

    // randomized stream, long enough to wrap the 4-bit counter
    for (int n = 0; n < 40; n++) begin
      instr($urandom_range(0, 3), $urandom_range(0, TO - 1), $urandom_range(0, TO - 1),
            rnd(), ($urandom_range(0, 3) != 0));
    end

    // illegal opcode traps; run ignored until reset
    instr(4, 0, 0, 1'b0, 1'b1);
    do_reset("reset_after_illegal");
    cyc(0, rnd(), 1'b1);
    instr(5, $urandom_range(0, TO - 1), 0, rnd(), 1'b1);
    do_reset("reset_after_illegal2");

    // watchdog expiry in FETCH
    cyc(0, rnd(), 1'b1);
    opcode = OP_R;
    for (int i = 0; i < TO; i++) cyc(1, 1'b0, 1'b1);
    m_to = 1'b1;
    repeat (3) cyc(15, rnd(), rnd());
    do_reset("reset_after_fetch_timeout");

    // watchdog expiry in MEM_READ
    cyc(0, rnd(), 1'b1);
    instr(0, 0, 0, 1'b0, 1'b1);
    opcode = OP_LW;
    cyc(1, 1'b1, 1'b1);
    cyc(2, rnd(), 1'b1);
    cyc(3, rnd(), 1'b1);
    for (int i = 0; i < TO; i++) cyc(4, 1'b0, 1'b1);
    m_to = 1'b1;
    repeat (2) cyc(15, rnd(), 1'b1);
    do_reset("reset_after_read_timeout");

    // reset in the middle of a store access
    cyc(0, rnd(), 1'b1);
    instr(3, 0, 0, 1'b1, 1'b1);
    opcode = OP_SW;
    cyc(1, 1'b1, 1'b1);
    cyc(2, rnd(), 1'b1);
    cyc(3, rnd(), 1'b1);
    cyc(6, 1'b0, 1'b1);
    cyc(6, 1'b0, 1'b1);
    mif.mem_ready = 1'b0;
    do_reset("reset_mid_write");
    cyc(0, rnd(), 1'b0);

    @(negedge clk);
    #1;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", expq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
